frame_reg_sync: RTL

//  RTL receiving end of the register bus that the sim register BFM drives.

---
 rtl/frame_reg_sync_if.sv | 33 +++
 rtl/frame_reg_sync.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/frame_reg_sync_if.sv
// Register-bus and frame-control bundle between the control-register
// decoder (master side) and frame_reg_sync (slave side).
interface frame_reg_sync_if #(
  parameter int REG_WD       = 32,
  parameter int SHORT_REG_WD = 16
);
  logic                    i_wr_en;
  logic [3:0]              iv_wr_addr;
  logic [REG_WD-1:0]       iv_wr_data;
  logic                    i_rd_en;
  logic [3:0]              iv_rd_addr;
  logic [REG_WD-1:0]       ov_rd_data;
  logic                    o_rd_valid;
  logic                    i_fval;
  logic [2:0]              ov_test_image_sel;
  logic [REG_WD-1:0]       ov_pixel_format;
  logic                    o_pulse_filter_en;
  logic [SHORT_REG_WD-1:0] ov_roi_pic_width;
  logic                    o_reg_update;
  logic                    o_wr_err;

  modport master (
    output i_wr_en, iv_wr_addr, iv_wr_data, i_rd_en, iv_rd_addr, i_fval,
    input  ov_rd_data, o_rd_valid, ov_test_image_sel, ov_pixel_format,
           o_pulse_filter_en, ov_roi_pic_width, o_reg_update, o_wr_err
  );

  modport slave (
    input  i_wr_en, iv_wr_addr, iv_wr_data, i_rd_en, iv_rd_addr, i_fval,
    output ov_rd_data, o_rd_valid, ov_test_image_sel, ov_pixel_format,
           o_pulse_filter_en, ov_roi_pic_width, o_reg_update, o_wr_err
  );
endinterface

// File: rtl/frame_reg_sync.sv
// Frame-synchronised register bank: validated writes land in a shadow bank,
// which is copied to the active outputs at the falling edge of i_fval.
//
//  state   | meaning
//  --------+---------------------------------------------------------------
//  S_INIT  | no frame seen yet; accepted writes go straight to active too
//  S_FRAME | frame in progress; writes to shadow only, transfer on fall
//  S_BLANK | between frames; writes to shadow only, wait for next frame
module frame_reg_sync #(
  parameter int REG_WD       = 32,
  parameter int SHORT_REG_WD = 16
) (
  input  logic              clk_sensor_pix,
  input  logic              reset_sensor_pix,
  frame_reg_sync_if.slave   bus
);

  localparam logic [REG_WD-1:0] FMT_RST  = REG_WD'(32'h0108_0001);
  localparam logic [REG_WD-1:0] FMT_LEG1 = REG_WD'(32'h0110_0003);
  localparam logic [REG_WD-1:0] FMT_LEG2 = REG_WD'(32'h0108_0008);
  localparam logic [REG_WD-1:0] FMT_LEG3 = REG_WD'(32'h0110_000c);

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_FRAME = 2'd1,
    S_BLANK = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic                    fval_d;
  logic                    fall;
  logic                    dirty, dirty_nxt;
  logic                    wr_hit, wr_legal, wr_ok, wr_rej;
  logic                    wr_to_active;
  logic                    xfer;
  logic                    upd_nxt;

  logic [2:0]              sh_sel,   act_sel;
  logic [REG_WD-1:0]       sh_fmt,   act_fmt;
  logic                    sh_pulse, act_pulse;
  logic [SHORT_REG_WD-1:0] sh_roi,   act_roi;

  logic [REG_WD-1:0]       rd_mux;
  logic [REG_WD-1:0]       rd_data;
  logic                    rd_valid;
  logic                    reg_update;
  logic                    wr_err;

  assign fall = fval_d & ~bus.i_fval;

  // Address decode and per-field legality of the incoming write.
  always_comb begin
    wr_hit   = bus.i_wr_en && (bus.iv_wr_addr < 4'd4);
    wr_legal = 1'b0;
    case (bus.iv_wr_addr[1:0])
      2'd0: wr_legal = (bus.iv_wr_data[2:0] == 3'b000) || (bus.iv_wr_data[2:0] == 3'b001) ||
                       (bus.iv_wr_data[2:0] == 3'b110) || (bus.iv_wr_data[2:0] == 3'b010);
      2'd1: wr_legal = (bus.iv_wr_data == FMT_RST)  || (bus.iv_wr_data == FMT_LEG1) ||
                       (bus.iv_wr_data == FMT_LEG2) || (bus.iv_wr_data == FMT_LEG3);
      2'd2: wr_legal = 1'b1;
      2'd3: wr_legal = (bus.iv_wr_data[SHORT_REG_WD-1:0] != '0);
      default: wr_legal = 1'b0;
    endcase
    wr_ok  = wr_hit & wr_legal;
    wr_rej = wr_hit & ~wr_legal;
  end

  // State register.
  always_ff @(posedge clk_sensor_pix) begin
    if (reset_sensor_pix) state <= S_INIT;
    else                  state <= state_nxt;
  end

  // Next state plus transfer/dirty/update control.
  always_comb begin
    state_nxt    = state;
    dirty_nxt    = dirty;
    wr_to_active = 1'b0;
    xfer         = 1'b0;
    upd_nxt      = 1'b0;
    case (state)
      S_INIT: begin
        if (wr_ok) begin
          wr_to_active = 1'b1;
          upd_nxt      = 1'b1;
        end
        if (bus.i_fval) state_nxt = S_FRAME;
      end
      S_FRAME: begin
        if (fall) begin
          state_nxt = S_BLANK;
          if (dirty) begin
            xfer      = 1'b1;
            dirty_nxt = 1'b0;
            upd_nxt   = 1'b1;
          end
        end
        // A write in the fall cycle must survive the transfer clearing dirty.
        if (wr_ok) dirty_nxt = 1'b1;
      end
      S_BLANK: begin
        if (wr_ok) dirty_nxt = 1'b1;
        if (bus.i_fval) state_nxt = S_FRAME;
      end
      default: state_nxt = S_INIT;
    endcase
  end

  // Frame-valid delay and dirty flag.
  always_ff @(posedge clk_sensor_pix) begin
    if (reset_sensor_pix) begin
      fval_d <= 1'b0;
      dirty  <= 1'b0;
    end else begin
      fval_d <= bus.i_fval;
      dirty  <= dirty_nxt;
    end
  end

  // Shadow bank: takes every accepted write.
  always_ff @(posedge clk_sensor_pix) begin
    if (reset_sensor_pix) begin
      sh_sel   <= 3'b000;
      sh_fmt   <= FMT_RST;
      sh_pulse <= 1'b0;
      sh_roi   <= '0;
    end else if (wr_ok) begin
      case (bus.iv_wr_addr[1:0])
        2'd0: sh_sel   <= bus.iv_wr_data[2:0];
        2'd1: sh_fmt   <= bus.iv_wr_data;
        2'd2: sh_pulse <= bus.iv_wr_data[0];
        2'd3: sh_roi   <= bus.iv_wr_data[SHORT_REG_WD-1:0];
        default: ;
      endcase
    end
  end

  // Active bank: copy of the pre-write shadow at a dirty fall, or direct write before the first frame.
  always_ff @(posedge clk_sensor_pix) begin
    if (reset_sensor_pix) begin
      act_sel   <= 3'b000;
      act_fmt   <= FMT_RST;
      act_pulse <= 1'b0;
      act_roi   <= '0;
    end else if (xfer) begin
      act_sel   <= sh_sel;
      act_fmt   <= sh_fmt;
      act_pulse <= sh_pulse;
      act_roi   <= sh_roi;
    end else if (wr_to_active) begin
      case (bus.iv_wr_addr[1:0])
        2'd0: act_sel   <= bus.iv_wr_data[2:0];
        2'd1: act_fmt   <= bus.iv_wr_data;
        2'd2: act_pulse <= bus.iv_wr_data[0];
        2'd3: act_roi   <= bus.iv_wr_data[SHORT_REG_WD-1:0];
        default: ;
      endcase
    end
  end

  // Read decode: 0..3 shadow, 8..11 active, everything else zero.
  always_comb begin
    rd_mux = '0;
    case (bus.iv_rd_addr)
      4'd0:  rd_mux = {{(REG_WD-3){1'b0}}, sh_sel};
      4'd1:  rd_mux = sh_fmt;
      4'd2:  rd_mux = {{(REG_WD-1){1'b0}}, sh_pulse};
      4'd3:  rd_mux = {{(REG_WD-SHORT_REG_WD){1'b0}}, sh_roi};
      4'd8:  rd_mux = {{(REG_WD-3){1'b0}}, act_sel};
      4'd9:  rd_mux = act_fmt;
      4'd10: rd_mux = {{(REG_WD-1){1'b0}}, act_pulse};
      4'd11: rd_mux = {{(REG_WD-SHORT_REG_WD){1'b0}}, act_roi};
      default: rd_mux = '0;
    endcase
  end

  // Registered read data and one-cycle strobes.
  always_ff @(posedge clk_sensor_pix) begin
    if (reset_sensor_pix) begin
      rd_data    <= '0;
      rd_valid   <= 1'b0;
      reg_update <= 1'b0;
      wr_err     <= 1'b0;
    end else begin
      rd_valid   <= bus.i_rd_en;
      if (bus.i_rd_en) rd_data <= rd_mux;
      reg_update <= upd_nxt;
      wr_err     <= wr_rej;
    end
  end

  assign bus.ov_rd_data        = rd_data;
  assign bus.o_rd_valid        = rd_valid;
  assign bus.ov_test_image_sel = act_sel;
  assign bus.ov_pixel_format   = act_fmt;
  assign bus.o_pulse_filter_en = act_pulse;
  assign bus.ov_roi_pic_width  = act_roi;
  assign bus.o_reg_update      = reg_update;
  assign bus.o_wr_err          = wr_err;

endmodule
